tick_gen: RTL and testbench

- Upstream stage of the 4-bit display counter.
- Replaces the free-running divided clock with a single-cycle enable strobe `tick` in the `clk` domain, so the counter flops can run on `clk` itself.
- Adds run/pause control and a debounced single-step push-button, so the counter can be advanced manually on the board.
- Sits between the board clock/switches and the counter's enable input.

---
 rtl/tick_gen_pkg.sv | 13 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/tick_gen.sv | 116 +++++++++++
 tb/tb_tick_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: mode encoding and default parameter values.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    MODE_PAUSE = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10
  } mode_t;

  localparam int unsigned TG_DEFAULT_DIV = 50_000_000;
  localparam int unsigned TG_DEB_CYCLES  = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse
// of the accepted (debounced) level.
module btn_debounce #(
  parameter int          DEB_W      = 20,
  parameter int unsigned DEB_CYCLES = tick_gen_pkg::TG_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             btn_p0;
  logic             btn_p1;
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_p0    <= 1'b0;
      btn_p1    <= 1'b0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_p0   <= btn_raw;
      btn_p1   <= btn_p0;
      btn_rise <= 1'b0;
      // a single agreeing sample restarts the stability window
      if (btn_p1 == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_level <= btn_p1;
        btn_rise  <= btn_p1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Enable-strobe generator for the display counter: run/pause/step FSM, loadable prescaler.
// Optional square-wave output clk_sq is built only when TICK_GEN_SQUARE_EN is defined.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          DIV_W       = 27,
  parameter int unsigned DEFAULT_DIV = TG_DEFAULT_DIV,
  parameter int          DEB_W       = 20,
  parameter int unsigned DEB_CYCLES  = TG_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             run_en,
  input  logic             step_btn,
  output logic             tick,
  output logic [1:0]       mode,
  output logic             clk_sq
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(1);

  logic             run_p0;
  logic             run_p1;
  logic             step_level;
  logic             step_pulse;
  logic             step_req;
  logic             terminal;
  mode_t            state;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;

  btn_debounce #(
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (step_btn),
    .btn_level (step_level),
    .btn_rise  (step_pulse)
  );

  // a rise is only meaningful while the accepted level is high
  assign step_req = step_pulse & step_level;
  assign terminal = (cnt == div_reg - 1'b1);
  assign mode     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_p0  <= 1'b0;
      run_p1  <= 1'b0;
      state   <= MODE_PAUSE;
      div_reg <= DIV_RST;
      cnt     <= '0;
      tick    <= 1'b0;
    end else begin
      run_p0 <= run_en;
      run_p1 <= run_p0;
      tick   <= 1'b0;
      case (state)
        MODE_PAUSE: begin
          cnt <= '0;
          if (run_p1) begin
            state <= MODE_RUN;
          end else if (step_req) begin
            state <= MODE_STEP;
          end
        end
        MODE_RUN: begin
          if (!run_p1) begin
            state <= MODE_PAUSE;
            cnt   <= '0;
          end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MODE_STEP: begin
          cnt   <= '0;
          tick  <= 1'b1;
          state <= MODE_PAUSE;
        end
        default: begin
          cnt   <= '0;
          state <= MODE_PAUSE;
        end
      endcase
      // a divisor load restarts the period and overrides a coincident terminal count
      if (div_load) begin
        div_reg <= (div_val < DIV_MIN) ? DIV_MIN : div_val;
        cnt     <= '0;
        if (state == MODE_RUN) begin
          tick <= 1'b0;
        end
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sq <= 1'b0;
    end else if (tick) begin
      clk_sq <= ~clk_sq;
    end
  end
`else
  assign clk_sq = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with a short divisor and debounce window.
module tb_tick_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] div_val;
  logic       div_load;
  logic       run_en;
  logic       step_btn;
  logic       tick;
  logic [1:0] mode;
  logic       clk_sq;

  int checks = 0;
  int errors = 0;

  tick_gen #(
    .DIV_W       (8),
    .DEFAULT_DIV (4),
    .DEB_W       (4),
    .DEB_CYCLES  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .div_val  (div_val),
    .div_load (div_load),
    .run_en   (run_en),
    .step_btn (step_btn),
    .tick     (tick),
    .mode     (mode),
    .clk_sq   (clk_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // count ticks over n samples; bad = ticks whose spacing from the previous differs from period
  task automatic measure(input int n, input int period, output int count, output int first,
                         output int bad);
    int last;
    count = 0;
    first = -1;
    bad   = 0;
    last  = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0 && (i - last) != period) bad++;
        last = i;
        count++;
      end
    end
  endtask

  initial begin
    int cnt_t, first_t, bad_t, steps, highs, run_len, max_run;
    bit found;

    rst_n    = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    run_en   = 1'b0;
    step_btn = 1'b0;
    cyc(2);
    chk("rst_tick", tick, 0);
    chk("rst_mode", mode, 0);
    chk("rst_clk_sq", clk_sq, 0);
    rst_n = 1'b1;

    // 1: free-run at the default divisor
    run_en = 1'b1;
    cyc(2);
    chk("run_latency_pause", mode, 0);
    cyc(1);
    chk("run_latency_run", mode, 1);
    measure(16, 4, cnt_t, first_t, bad_t);
    chk("div4_count", cnt_t, 4);
    chk("div4_first", first_t, 3);
    chk("div4_spacing", bad_t, 0);

    // 2: load zero (clamped to 1), then load 6 on a terminal count
    div_load = 1'b1;
    div_val  = 8'd0;
    cyc(1);
    div_load = 1'b0;
    chk("load0_no_tick", tick, 0);
    measure(7, 1, cnt_t, first_t, bad_t);
    chk("div1_count", cnt_t, 7);
    chk("div1_first", first_t, 0);
    div_load = 1'b1;
    div_val  = 8'd6;
    cyc(1);
    div_load = 1'b0;
    chk("load6_wins_terminal", tick, 0);
    measure(12, 6, cnt_t, first_t, bad_t);
    chk("div6_count", cnt_t, 2);
    chk("div6_first", first_t, 5);
    chk("div6_spacing", bad_t, 0);

    // 4: a press while running leaves the cadence alone
    step_btn = 1'b1;
    measure(12, 6, cnt_t, first_t, bad_t);
    chk("run_press_count", cnt_t, 2);
    chk("run_press_first", first_t, 5);
    chk("run_press_mode", mode, 1);
    step_btn = 1'b0;

    // 3: pause, then a bouncy press followed by a clean press
    run_en = 1'b0;
    cyc(10);
    chk("pause_mode", mode, 0);
    chk("pause_tick", tick, 0);
    cnt_t = 0;
    steps = 0;
    for (int i = 0; i < 19; i++) begin
      if (i < 5) step_btn = (i % 2 == 0);
      else if (i < 15) step_btn = 1'b1;
      @(negedge clk);
      if (tick === 1'b1) cnt_t++;
      if (mode === 2'b10) steps++;
    end
    chk("bounce_ticks", cnt_t, 1);
    chk("bounce_step_cycles", steps, 1);
    chk("bounce_end_mode", mode, 0);
    step_btn = 1'b0;
    measure(8, 0, cnt_t, first_t, bad_t);
    chk("release_ticks", cnt_t, 0);
    step_btn = 1'b1;
    measure(10, 0, cnt_t, first_t, bad_t);
    chk("second_press_ticks", cnt_t, 1);
    step_btn = 1'b0;
    cyc(8);

    // 5: asynchronous reset while tick is high
    run_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    chk("wait_tick_found", found, 1);
    #2;
    rst_n  = 1'b0;
    run_en = 1'b0;
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_mode", mode, 0);
    chk("async_rst_clk_sq", clk_sq, 0);
    #1;
    rst_n = 1'b1;
    measure(6, 0, cnt_t, first_t, bad_t);
    chk("post_rst_no_tick", cnt_t, 0);
    chk("post_rst_mode", mode, 0);
    run_en = 1'b1;
    cyc(3);
    chk("post_rst_run", mode, 1);
    measure(8, 4, cnt_t, first_t, bad_t);
    chk("post_rst_div_count", cnt_t, 2);
    chk("post_rst_div_first", first_t, 3);
    chk("post_rst_div_spacing", bad_t, 0);

    // 6: square-wave output
    highs   = 0;
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (clk_sq === 1'b1) begin
        highs++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
`ifdef TICK_GEN_SQUARE_EN
    chk("sq_high_cycles", highs, 8);
    chk("sq_max_high_run", max_run, 4);
`else
    chk("sq_tied_low", highs, 0);
    chk("sq_no_run", max_run, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
